comm_bit_framer: RTL
====================

Name: comm_bit_framer

Overview:
Upstream neighbour of comm_process. Consumes the demodulated serial bit stream from the line decoder and hunts for the start byte. It then forwards length and payload bits to comm_process on new_bit_enable/new_bit, and checks the trailing CRC-16 and stop byte. It reports the outcome through start_byte_detected, decoding_success and end_of_packet, the signals comm_process already consumes.

Parameters:
START_BYTE, 8'b10011001, start pattern; compared MSB-first against the last 8 received bits.
STOP_BYTE, 8'b11111111, required trailer byte.
MAX_BYTES, 16, maximum legal length-field value.
TIMEOUT, 1000, inclk cycles allowed between rx_bit_valid strobes once in a packet.

Ports:
inclk  in  1  system clock (20 MHz).
reset  in  1  asynchronous, active-high reset.
rx_bit_valid  in  1  one-cycle strobe; rx_bit is valid this cycle.
rx_bit  in  1  decoded line bit.
start_byte_detected  out  1  level; high from start-byte match until the end_of_packet cycle inclusive.
new_bit_enable  out  1  one-cycle strobe; forwarded bit valid.
new_bit  out  1  forwarded bit.
decoding_success  out  1  level; CRC and stop byte both good; held until next start-byte match or reset.
end_of_packet  out  1  one-cycle pulse closing every packet, good or bad.
crc_error  out  1  one-cycle pulse, coincident with end_of_packet, on CRC mismatch.
frame_error  out  1  one-cycle pulse, coincident with end_of_packet, on bad length, bad stop byte or timeout.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state HUNT, shift register 0, CRC 16'hFFFF, counters 0.
- All state advances happen only on rx_bit_valid, except the timeout and the DONE->HUNT step.
- HUNT: shift rx_bit into an 8-bit register (new bit enters at LSB).
  - On a match with START_BYTE, next cycle: start_byte_detected=1, decoding_success=0, CRC=16'hFFFF, bit counter=0, go to LEN.
  - Start-byte bits are not forwarded.
- LEN: 8 bits, MSB first.
  - Each bit is forwarded: new_bit_enable=1 and new_bit=rx_bit, one cycle after rx_bit_valid.
  - Each bit also updates the CRC.
  - After the 8th bit: if value L is 0 or greater than MAX_BYTES, close as frame error. Otherwise go to PAYLOAD with remaining = L*8 bits.
- PAYLOAD: forward each bit and update CRC. When the remaining count reaches 0, go to CRC.
- CRC: 16 bits, MSB first, not forwarded, shifted into a receive register. After 16 bits, compare with the computed CRC, record the match, go to STOP.
- CRC algorithm: CRC-16-CCITT, poly 16'h1021, bit-serial, MSB-first, no reflection, no final XOR. Covers length and payload bits only.
- STOP: 8 bits, not forwarded. After the 8th bit, go to DONE.
- DONE: one cycle.
  - end_of_packet=1, start_byte_detected drops the following cycle.
  - decoding_success=1 only if CRC matched and the stop byte equals STOP_BYTE.
  - crc_error pulses if CRC mismatched.
  - frame_error pulses if the stop byte is wrong.
  - Then go to HUNT with the shift register cleared.
- Timeout: a cycle counter resets on each rx_bit_valid and counts in LEN/PAYLOAD/CRC/STOP. When it reaches TIMEOUT: end_of_packet and frame_error pulse, decoding_success=0, return to HUNT. Timeout has priority over an rx_bit_valid arriving in the same cycle; that bit is dropped.
- Bits arriving during DONE are ignored.
- No start-byte search inside a packet: START_BYTE patterns in the payload are forwarded as data.
- Forward latency: new_bit_enable follows rx_bit_valid by exactly 1 cycle. At most one strobe per rx_bit_valid.
- Reset mid-packet: all outputs go to 0 immediately. No end_of_packet is issued.

Test Plan:
- Good packet: idle bits 0101…, START_BYTE, L=8'h02, payload 8'hA5 8'h3C, correct CRC, 8'hFF. Required: 24 new_bit_enable strobes carrying 00000010 10100101 00111100. Then end_of_packet with decoding_success=1 (held), crc_error=0, frame_error=0.
- CRC corruption: same packet with one CRC bit flipped. Required: 24 forwarded bits; end_of_packet with crc_error=1 and decoding_success=0.
- Bad length: L=8'h00, then L=8'h11 with MAX_BYTES=16. Required in each case: exactly 8 forwarded bits, then end_of_packet+frame_error. The next valid packet decodes normally.
- Stop/timeout: a good CRC with stop byte 8'hFE gives frame_error=1, decoding_success=0. Stalling rx_bit_valid mid-payload for TIMEOUT cycles gives end_of_packet+frame_error exactly TIMEOUT cycles after the last strobe.
- Embedded pattern / reset: a payload containing 8'b10011001 is forwarded as data with no restart. Asserting reset mid-payload drops all outputs asynchronously, and a subsequent good packet decodes with decoding_success=1.

Source files
------------

// File: rtl/comm_bit_framer.sv
// Bit-level packet framer: hunts for the start byte, forwards length and
// payload bits, then checks the trailing CRC-16 and stop byte.
module comm_bit_framer #(
  parameter logic [7:0] START_BYTE = 8'b10011001,
  parameter logic [7:0] STOP_BYTE  = 8'b11111111,
  parameter int         MAX_BYTES  = 16,
  parameter int         TIMEOUT    = 1000
) (
  input  logic inclk,
  input  logic reset,
  input  logic rx_bit_valid,
  input  logic rx_bit,
  output logic start_byte_detected,
  output logic new_bit_enable,
  output logic new_bit,
  output logic decoding_success,
  output logic end_of_packet,
  output logic crc_error,
  output logic frame_error
);

  localparam int         TW    = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_L = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CRC,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [15:0]   sr, sr_n;
  logic [15:0]   crc, crc_n;
  logic [7:0]    cnt, cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          crc_ok, crc_ok_n;
  logic          sbd_n, nbe_n, nb_n, ds_n;
  logic          eop_n, ce_n, fe_n;
  logic [15:0]   shifted;
  logic [15:0]   crc_upd;
  logic          in_pkt;
  logic          tmo_hit;
  logic          stop_ok;
  logic          len_bad;

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state               <= S_HUNT;
      sr                  <= '0;
      crc                 <= 16'hFFFF;
      cnt                 <= '0;
      tmo                 <= '0;
      crc_ok              <= 1'b0;
      start_byte_detected <= 1'b0;
      new_bit_enable      <= 1'b0;
      new_bit             <= 1'b0;
      decoding_success    <= 1'b0;
      end_of_packet       <= 1'b0;
      crc_error           <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      state               <= state_n;
      sr                  <= sr_n;
      crc                 <= crc_n;
      cnt                 <= cnt_n;
      tmo                 <= tmo_n;
      crc_ok              <= crc_ok_n;
      start_byte_detected <= sbd_n;
      new_bit_enable      <= nbe_n;
      new_bit             <= nb_n;
      decoding_success    <= ds_n;
      end_of_packet       <= eop_n;
      crc_error           <= ce_n;
      frame_error         <= fe_n;
    end
  end

  always_comb begin
    shifted  = {sr[14:0], rx_bit};
    crc_upd  = {crc[14:0], 1'b0}
             ^ ((crc[15] ^ rx_bit) ? 16'h1021 : 16'h0000);
    in_pkt   = (state == S_LEN) || (state == S_PAYLOAD)
            || (state == S_CRC) || (state == S_STOP);
    tmo_hit  = in_pkt && (tmo == TW'(TIMEOUT - 1));
    stop_ok  = (shifted[7:0] == STOP_BYTE);
    len_bad  = (shifted[7:0] == 8'd0) || (shifted[7:0] > MAX_L);
    state_n  = state;
    sr_n     = sr;
    crc_n    = crc;
    cnt_n    = cnt;
    tmo_n    = tmo;
    crc_ok_n = crc_ok;
    sbd_n    = start_byte_detected;
    nbe_n    = 1'b0;
    nb_n     = new_bit;
    ds_n     = decoding_success;
    eop_n    = 1'b0;
    ce_n     = 1'b0;
    fe_n     = 1'b0;
    if (in_pkt) begin
      tmo_n = rx_bit_valid ? '0 : tmo + 1'b1;
    end
    // A stalled line closes the packet; a bit landing on that edge is lost.
    if (tmo_hit) begin
      state_n = S_DONE;
      eop_n   = 1'b1;
      fe_n    = 1'b1;
      ds_n    = 1'b0;
    end else begin
      unique case (state)
        S_HUNT: begin
          if (rx_bit_valid) begin
            sr_n = shifted;
            if (shifted[7:0] == START_BYTE) begin
              state_n = S_LEN;
              sbd_n   = 1'b1;
              ds_n    = 1'b0;
              crc_n   = 16'hFFFF;
              cnt_n   = '0;
              tmo_n   = '0;
            end
          end
        end
        S_LEN: begin
          if (rx_bit_valid) begin
            sr_n  = shifted;
            nbe_n = 1'b1;
            nb_n  = rx_bit;
            crc_n = crc_upd;
            cnt_n = cnt + 8'd1;
            if (cnt == 8'd7) begin
              unique case (1'b1)
                len_bad: begin
                  state_n = S_DONE;
                  eop_n   = 1'b1;
                  fe_n    = 1'b1;
                end
                default: begin
                  state_n = S_PAYLOAD;
                  cnt_n   = {shifted[4:0], 3'b000};
                end
              endcase
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_bit_valid) begin
            sr_n  = shifted;
            nbe_n = 1'b1;
            nb_n  = rx_bit;
            crc_n = crc_upd;
            cnt_n = cnt - 8'd1;
            if (cnt == 8'd1) begin
              state_n = S_CRC;
              cnt_n   = '0;
            end
          end
        end
        S_CRC: begin
          if (rx_bit_valid) begin
            sr_n  = shifted;
            cnt_n = cnt + 8'd1;
            if (cnt == 8'd15) begin
              crc_ok_n = (shifted == crc);
              state_n  = S_STOP;
              cnt_n    = '0;
            end
          end
        end
        S_STOP: begin
          if (rx_bit_valid) begin
            sr_n  = shifted;
            cnt_n = cnt + 8'd1;
            if (cnt == 8'd7) begin
              state_n = S_DONE;
              eop_n   = 1'b1;
              ds_n    = crc_ok && stop_ok;
              ce_n    = !crc_ok;
              fe_n    = !stop_ok;
            end
          end
        end
        S_DONE: begin
          state_n = S_HUNT;
          sbd_n   = 1'b0;
          sr_n    = '0;
          cnt_n   = '0;
          tmo_n   = '0;
        end
        default: state_n = S_HUNT;
      endcase
    end
  end

endmodule
